ld_precision_unpack_fifo: RTL and testbench

- Load-data buffer between the global/local memory read-response path and the PE register-bank write port.
- Generalises the fixed 32-bit load data FIFO: parametrised depth, width and outstanding-request credit.
- Adds precision-mode unpacking: each memory word yields 1, 2 or 4 register writes (32b/16b/8b) to consecutive register addresses.

---
 rtl/ld_precision_unpack_fifo_pkg.sv | 9 +
 rtl/ld_precision_unpack_fifo_if.sv | 23 ++
 rtl/ld_precision_unpack_fifo_sync_fifo.sv | 31 +++
 rtl/ld_precision_unpack_fifo.sv | 63 ++++++
 tb/tb_ld_precision_unpack_fifo.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ld_precision_unpack_fifo_pkg.sv
// ld_precision_unpack_fifo_pkg: precision modes, default sizing and sub-word count helper
package ld_precision_unpack_fifo_pkg;
  localparam int LD_DATA_FIFO_DEPTH = 16;
  localparam int MAX_OUTSTANDING_LD_REQ = 4;
  typedef enum logic [1:0] {PREC_32B = 2'd0, PREC_16B = 2'd1, PREC_8B = 2'd2} precision_e;
  function automatic logic [2:0] n_sub(input logic [1:0] p);
    return p == PREC_16B ? 3'd2 : p == PREC_8B ? 3'd4 : 3'd1;
  endfunction
endpackage

// File: rtl/ld_precision_unpack_fifo_if.sv
// ld_precision_unpack_fifo_if: request credit, read response and register write port bundle
interface ld_precision_unpack_fifo_if #(
  parameter int DATA_L = 32,
  parameter int REG_ADDR_L = 5,
  parameter int PRECISION_CONFIG_L = 2
);
  logic [PRECISION_CONFIG_L-1:0] precision_config;
  logic req_rdy;
  logic req_issue;
  logic resp_vld;
  logic [DATA_L-1:0] resp_data;
  logic [REG_ADDR_L-1:0] resp_reg;
  logic out_vld;
  logic [DATA_L-1:0] out_data;
  logic [REG_ADDR_L-1:0] out_reg;
  logic out_rdy;
  logic idle;
  logic err;
  modport master (output precision_config, req_issue, resp_vld, resp_data, resp_reg, out_rdy,
                  input req_rdy, out_vld, out_data, out_reg, idle, err);
  modport slave (input precision_config, req_issue, resp_vld, resp_data, resp_reg, out_rdy,
                 output req_rdy, out_vld, out_data, out_reg, idle, err);
endinterface

// File: rtl/ld_precision_unpack_fifo_sync_fifo.sv
// ld_precision_unpack_fifo_sync_fifo: registered FIFO with wrap-bit pointers and combinational head
module ld_precision_unpack_fifo_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  assign count = wr_ptr - rd_ptr;
  assign empty = count == '0;
  assign rdata = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/ld_precision_unpack_fifo.sv
// ld_precision_unpack_fifo: credit-limited load-data FIFO that unpacks each memory word
// into 1, 2 or 4 register writes according to the latched precision mode.
module ld_precision_unpack_fifo
  import ld_precision_unpack_fifo_pkg::*;
#(
  parameter int DATA_L = 32,
  parameter int FIFO_DEPTH = LD_DATA_FIFO_DEPTH,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_LD_REQ,
  parameter int REG_ADDR_L = 5,
  parameter int PRECISION_CONFIG_L = 2
) (
  input logic clk,
  input logic rst_n,
  ld_precision_unpack_fifo_if.slave bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam int FW = DATA_L + REG_ADDR_L;
  localparam logic [DATA_L-1:0] M16 = {{(DATA_L/2){1'b0}}, {(DATA_L/2){1'b1}}};
  localparam logic [DATA_L-1:0] M8 = {{(DATA_L*3/4){1'b0}}, {(DATA_L/4){1'b1}}};
  logic [CW-1:0] outstanding;
  logic [PRECISION_CONFIG_L-1:0] cfg_q;
  logic [1:0] sub_idx;
  logic err_q;
  logic [FW-1:0] head;
  logic [DATA_L-1:0] head_data;
  logic [REG_ADDR_L-1:0] head_reg;
  logic empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [2:0] n;
  logic fire, last, pop, inc, dec;
  int sh;
  ld_precision_unpack_fifo_sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(dec), .pop(pop), .wdata({bus.resp_data, bus.resp_reg}),
    .rdata(head), .empty(empty), .count(count)
  );
  assign {head_data, head_reg} = head;
  assign n = n_sub(cfg_q[1:0]);
  assign sh = n == 3'd4 ? int'(sub_idx) * (DATA_L/4) : n == 3'd2 ? int'(sub_idx) * (DATA_L/2) : 0;
  assign bus.req_rdy = int'(outstanding) < MAX_OUTSTANDING && int'(outstanding) + int'(count) < FIFO_DEPTH;
  assign bus.out_vld = !empty;
  assign bus.out_data = (head_data >> sh) & (n == 3'd4 ? M8 : n == 3'd2 ? M16 : '1);
  assign bus.out_reg = head_reg + REG_ADDR_L'(sub_idx);
  assign bus.idle = empty && outstanding == '0;
  assign bus.err = err_q;
  assign fire = bus.out_vld && bus.out_rdy;
  assign last = {1'b0, sub_idx} == n - 3'd1;
  assign pop = fire && last;
  assign inc = bus.req_issue && bus.req_rdy;
  // responses with no request in flight are dropped rather than pushed
  assign dec = bus.resp_vld && outstanding != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      outstanding <= '0;
      cfg_q <= '0;
      sub_idx <= '0;
      err_q <= 1'b0;
    end else begin
      if (bus.idle) cfg_q <= bus.precision_config;
      if (inc != dec) outstanding <= inc ? outstanding + CW'(1) : outstanding - CW'(1);
      if (fire) sub_idx <= last ? 2'd0 : sub_idx + 2'd1;
      err_q <= err_q | (bus.req_issue && !bus.req_rdy) | (bus.resp_vld && outstanding == '0);
    end
endmodule

// File: tb/tb_ld_precision_unpack_fifo.sv
// tb_ld_precision_unpack_fifo: directed scenarios with hand-computed register writes
module tb_ld_precision_unpack_fifo;
  logic clk = 0;
  logic rst_n = 0;
  int passed = 0;
  int total = 0;
  ld_precision_unpack_fifo_if #(.DATA_L(32), .REG_ADDR_L(5), .PRECISION_CONFIG_L(2)) bus ();
  ld_precision_unpack_fifo #(.DATA_L(32), .FIFO_DEPTH(16), .MAX_OUTSTANDING(4), .REG_ADDR_L(5),
    .PRECISION_CONFIG_L(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got %h exp %h", name, got, exp);
    else passed++;
  endtask

  task automatic issue();
    bus.req_issue = 1;
    step();
    bus.req_issue = 0;
  endtask

  task automatic respond(logic [31:0] d, logic [4:0] r);
    bus.resp_vld = 1;
    bus.resp_data = d;
    bus.resp_reg = r;
    step();
    bus.resp_vld = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    bus.precision_config = 0;
    bus.req_issue = 0;
    bus.resp_vld = 0;
    bus.resp_data = 0;
    bus.resp_reg = 0;
    bus.out_rdy = 0;
    step(2);
    chk("rst_out_vld", 32'(bus.out_vld), 0);
    chk("rst_req_rdy", 32'(bus.req_rdy), 1);
    chk("rst_idle", 32'(bus.idle), 1);
    chk("rst_err", 32'(bus.err), 0);
    rst_n = 1;
    step();
  endtask

  task automatic test_32b();
    bus.precision_config = 0;
    bus.out_rdy = 1;
    step();
    issue();
    chk("32b_not_idle", 32'(bus.idle), 0);
    bus.resp_vld = 1;
    bus.resp_data = 32'hDEADBEEF;
    bus.resp_reg = 5;
    #1;
    chk("32b_no_bypass", 32'(bus.out_vld), 0);
    step();
    bus.resp_vld = 0;
    chk("32b_vld", 32'(bus.out_vld), 1);
    chk("32b_data", bus.out_data, 32'hDEADBEEF);
    chk("32b_reg", 32'(bus.out_reg), 5);
    step();
    chk("32b_popped", 32'(bus.out_vld), 0);
    chk("32b_idle", 32'(bus.idle), 1);
  endtask

  task automatic test_8b();
    logic [4:0] regs [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
    logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    bus.precision_config = 2;
    bus.out_rdy = 1;
    step();
    issue();
    respond(32'h44332211, 30);
    for (int i = 0; i < 4; i++) begin
      chk("8b_vld", 32'(bus.out_vld), 1);
      chk("8b_data", bus.out_data, vals[i]);
      chk("8b_reg", 32'(bus.out_reg), 32'(regs[i]));
      step();
    end
    chk("8b_popped", 32'(bus.out_vld), 0);
  endtask

  task automatic test_16b_backpressure();
    bus.precision_config = 1;
    bus.out_rdy = 0;
    step();
    issue();
    respond(32'hBBBBAAAA, 7);
    for (int i = 0; i < 3; i++) begin
      chk("16b_hold_data", bus.out_data, 32'hAAAA);
      chk("16b_hold_reg", 32'(bus.out_reg), 7);
      step();
    end
    bus.out_rdy = 1;
    chk("16b_lo_data", bus.out_data, 32'hAAAA);
    step();
    chk("16b_hi_data", bus.out_data, 32'hBBBB);
    chk("16b_hi_reg", 32'(bus.out_reg), 8);
    step();
    chk("16b_popped", 32'(bus.out_vld), 0);
  endtask

  task automatic test_credit();
    bus.precision_config = 0;
    bus.out_rdy = 0;
    step();
    for (int i = 0; i < 4; i++) issue();
    chk("cr_rdy_low", 32'(bus.req_rdy), 0);
    chk("cr_err_clean", 32'(bus.err), 0);
    issue();
    chk("cr_err_set", 32'(bus.err), 1);
    respond(32'hC0, 1);
    chk("cr_rdy_after_resp", 32'(bus.req_rdy), 1);
    bus.req_issue = 1;
    respond(32'hC1, 2);
    bus.req_issue = 0;
    chk("cr_issue_resp_same", 32'(bus.req_rdy), 1);
    for (int i = 0; i < 3; i++) respond(32'hC2 + i, 5'(3 + i));
    chk("cr_no_extra_credit", 32'(bus.idle), 0);
    bus.out_rdy = 1;
    step(5);
    chk("cr_drained_idle", 32'(bus.idle), 1);
    chk("cr_err_sticky", 32'(bus.err), 1);
    do_reset();
    chk("cr_err_cleared", 32'(bus.err), 0);
  endtask

  task automatic test_fifo_fill();
    bus.precision_config = 0;
    bus.out_rdy = 0;
    step();
    for (int i = 0; i < 16; i++) begin
      issue();
      respond(32'h1000_0000 + i, 5'(i));
    end
    chk("fill_rdy_low", 32'(bus.req_rdy), 0);
    bus.out_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_data", bus.out_data, 32'h1000_0000 + i);
      chk("fill_reg", 32'(bus.out_reg), i);
      step();
    end
    chk("fill_empty", 32'(bus.out_vld), 0);
    chk("fill_err", 32'(bus.err), 0);
  endtask

  task automatic test_config_reset();
    bus.precision_config = 0;
    bus.out_rdy = 0;
    step();
    issue();
    bus.precision_config = 2;
    step(2);
    respond(32'h44332211, 3);
    chk("cfg_ignored_data", bus.out_data, 32'h44332211);
    bus.out_rdy = 1;
    step(2);
    issue();
    respond(32'h44332211, 3);
    chk("cfg_8b_data", bus.out_data, 32'h11);
    bus.out_rdy = 0;
    issue();
    rst_n = 0;
    #1;
    chk("arst_out_vld", 32'(bus.out_vld), 0);
    chk("arst_req_rdy", 32'(bus.req_rdy), 1);
    chk("arst_idle", 32'(bus.idle), 1);
    #2;
    rst_n = 1;
    step();
    respond(32'hBAD, 9);
    chk("stray_err", 32'(bus.err), 1);
    chk("stray_dropped", 32'(bus.out_vld), 0);
  endtask

  initial begin
    test_reset();
    test_32b();
    test_8b();
    test_16b_backpressure();
    test_credit();
    test_fifo_fill();
    test_config_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
